// File: rtl/serial_frame_decrypt_pkg.sv
// rtl/serial_frame_decrypt_pkg.sv - shared types, defaults and helpers for the frame decrypt path
package serial_frame_decrypt_pkg;

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [3:0] DEF_SYNC_WORD = 4'b1011;
  localparam logic [7:0] DEF_KEY_SEED  = 8'hA5;
  localparam logic [7:0] DEF_KEY_TAPS  = 8'hB8;

  function automatic int frame_len(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

  // Right-shifting Fibonacci step; callers pass the state zero-extended to 32 bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input int key_w);
    logic fb;
    fb = ^(s & taps);
    return (s >> 1) | (32'(fb) << (key_w - 1));
  endfunction

endpackage

// File: rtl/serial_frame_decrypt_if.sv
// rtl/serial_frame_decrypt_if.sv - serial input and decoded output bundle
interface serial_frame_decrypt_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              ena;
  logic              data_enc;
  logic              clk_div;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              par_err;

  modport master (
    output ena, data_enc,
    input  clk_div, addr_out, data_out, frame_valid, par_err
  );

  modport slave (
    input  ena, data_enc,
    output clk_div, addr_out, data_out, frame_valid, par_err
  );
endinterface

// File: rtl/serial_frame_decrypt_lfsr_keystream.sv
// rtl/serial_frame_decrypt_lfsr_keystream.sv - reloadable LFSR keystream generator
module lfsr_keystream
  import serial_frame_decrypt_pkg::*;
#(
  parameter int              KEY_W    = 8,
  parameter logic [KEY_W-1:0] KEY_SEED = KEY_W'(DEF_KEY_SEED),
  parameter logic [KEY_W-1:0] KEY_TAPS = KEY_W'(DEF_KEY_TAPS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_step,
  output logic o_ks_bit
);

  logic [KEY_W-1:0] r_lfsr;

  if (KEY_W < 3 || KEY_W > 32) begin : g_bad_width
    $error("lfsr_keystream: KEY_W must be within 3..32");
  end
  if (KEY_SEED == '0) begin : g_bad_seed
    $error("lfsr_keystream: KEY_SEED must be nonzero");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= KEY_SEED;
    end else if (i_load) begin
      r_lfsr <= KEY_SEED;
    end else if (i_step) begin
      r_lfsr <= KEY_W'(lfsr_next(32'(r_lfsr), 32'(KEY_TAPS), KEY_W));
    end
  end

  assign o_ks_bit = r_lfsr[0];

endmodule

// File: rtl/serial_frame_decrypt.sv
// rtl/serial_frame_decrypt.sv - sync hunt, keystream decrypt, deframe and parity check
module serial_frame_decrypt
  import serial_frame_decrypt_pkg::*;
#(
  parameter int               ADDR_W    = 4,
  parameter int               DATA_W    = 4,
  parameter int               SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD),
  parameter int               KEY_W     = 8,
  parameter logic [KEY_W-1:0]  KEY_SEED  = KEY_W'(DEF_KEY_SEED),
  parameter logic [KEY_W-1:0]  KEY_TAPS  = KEY_W'(DEF_KEY_TAPS),
  parameter int               DIV_HALF  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_frame_decrypt_if.slave bus
);

  localparam int N     = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(N);
  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  if (ADDR_W < 1 || DATA_W < 1 || SYNC_W < 2 || DIV_HALF < 1) begin : g_bad_param
    $error("serial_frame_decrypt: parameter out of range");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SYNC_W-2:0]   r_sync_sr;
  logic [N-2:0]        r_payload;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_clk_div;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_frame_valid;
  logic                r_par_err;

  logic [SYNC_W-1:0]   w_sync_cand;
  logic                w_match;
  logic                w_ks;
  logic                w_plain;
  logic [N-1:0]        w_frame;
  logic                w_last;
  logic                w_lfsr_load;
  logic                w_lfsr_step;
  logic                w_frame_done;

  assign w_sync_cand = {r_sync_sr, bus.data_enc};
  assign w_match     = (w_sync_cand == SYNC_WORD);
  assign w_plain     = bus.data_enc ^ w_ks;
  assign w_frame     = {r_payload, w_plain};
  assign w_last      = (r_cnt == CNT_W'(N - 1));

  lfsr_keystream #(
    .KEY_W    (KEY_W),
    .KEY_SEED (KEY_SEED),
    .KEY_TAPS (KEY_TAPS)
  ) u_keystream (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_lfsr_load),
    .i_step   (w_lfsr_step),
    .o_ks_bit (w_ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_load  = 1'b0;
    w_lfsr_step  = 1'b0;
    w_frame_done = 1'b0;
    if (bus.ena) begin
      case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            w_state_nxt = ST_RECV;
            w_lfsr_load = 1'b1;
          end
        end
        ST_RECV: begin
          w_lfsr_step = 1'b1;
          if (w_last) begin
            w_state_nxt  = ST_HUNT;
            w_frame_done = 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // Pulses drop every clk regardless of ena; everything else is frozen when ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_sr     <= '0;
      r_payload     <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_frame_valid <= 1'b0;
      r_par_err     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_par_err     <= 1'b0;
      if (bus.ena) begin
        if (r_state == ST_HUNT) begin
          r_sync_sr <= w_sync_cand[SYNC_W-2:0];
          if (w_match) begin
            r_cnt <= '0;
          end
        end else begin
          r_payload <= w_frame[N-2:0];
          r_cnt     <= r_cnt + 1'b1;
          if (w_frame_done) begin
            r_cnt     <= '0;
            r_sync_sr <= '0;
            if (^w_frame == 1'b0) begin
              r_addr        <= w_frame[N-1 -: ADDR_W];
              r_data        <= w_frame[DATA_W:1];
              r_frame_valid <= 1'b1;
            end else begin
              r_par_err <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_clk_div <= 1'b0;
    end else if (bus.ena) begin
      if (r_div_cnt == DIV_W'(DIV_HALF - 1)) begin
        r_div_cnt <= '0;
        r_clk_div <= ~r_clk_div;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign bus.clk_div     = r_clk_div;
  assign bus.addr_out    = r_addr;
  assign bus.data_out    = r_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.par_err     = r_par_err;

endmodule

// File: tb/tb_serial_frame_decrypt.sv
// tb/tb_serial_frame_decrypt.sv - directed-vector bench for serial_frame_decrypt
module tb_serial_frame_decrypt;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_frame_decrypt_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  serial_frame_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Sync 1011 then ciphertext; keystream from seed A5 / taps B8 is 101001010.
  localparam logic [12:0] FRAME_3C  = 13'b1011_100110010;
  localparam logic [12:0] FRAME_BAD = 13'b1011_100110011;
  localparam logic [12:0] FRAME_A5  = 13'b1011_000000000;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int fv_times[$];
  int pe_n   = 0;
  int both_n = 0;
  int t0;
  int gap_at[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_valid) fv_times.push_back(cyc);
    if (bus.par_err) pe_n++;
    if (bus.frame_valid && bus.par_err) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic b);
    bus.ena      = 1'b1;
    bus.data_enc = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ena = 1'b0;
    repeat (n) begin
      bus.data_enc = ~bus.data_enc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [12:0] f);
    for (int i = 12; i >= 0; i--) send(f[i]);
  endtask

  task automatic clear_mon();
    fv_times.delete();
    pe_n = 0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ena      = 1'b0;
    bus.data_enc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(bus.addr_out), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("rst_pe", 32'(bus.par_err), 32'h0);
    chk("rst_clkdiv", 32'(bus.clk_div), 32'h0);
    rst_n = 1'b1;

    // Basic valid frame
    clear_mon();
    send_frame(FRAME_3C);
    chk("s1_fv", 32'(bus.frame_valid), 32'h1);
    chk("s1_pe", 32'(bus.par_err), 32'h0);
    chk("s1_addr", 32'(bus.addr_out), 32'h3);
    chk("s1_data", 32'(bus.data_out), 32'hC);
    idle(2);
    chk("s1_fv_fall", 32'(bus.frame_valid), 32'h0);
    chk("s1_fv_count", 32'(fv_times.size()), 32'h1);

    // All-zero ciphertext decrypts to addr A, data 5
    clear_mon();
    send_frame(FRAME_A5);
    chk("a5_fv", 32'(bus.frame_valid), 32'h1);
    chk("a5_addr", 32'(bus.addr_out), 32'hA);
    chk("a5_data", 32'(bus.data_out), 32'h5);
    idle(1);

    // Parity error keeps previous outputs
    clear_mon();
    send_frame(FRAME_BAD);
    chk("s2_pe", 32'(bus.par_err), 32'h1);
    chk("s2_fv", 32'(bus.frame_valid), 32'h0);
    chk("s2_addr_held", 32'(bus.addr_out), 32'hA);
    chk("s2_data_held", 32'(bus.data_out), 32'h5);
    idle(2);
    chk("s2_pe_count", 32'(pe_n), 32'h1);
    chk("s2_fv_count", 32'(fv_times.size()), 32'h0);

    // ena gaps totalling 3 cycles inside the frame
    clear_mon();
    for (int j = 0; j < 3; j++) gap_at[j] = int'($urandom_range(1, 12));
    for (int i = 12; i >= 0; i--) begin
      for (int j = 0; j < 3; j++) if (gap_at[j] == 12 - i) idle(1);
      send(FRAME_3C[i]);
      if (i == 12) t0 = cyc;
    end
    idle(2);
    chk("s4_fv_count", 32'(fv_times.size()), 32'h1);
    chk("s4_latency", 32'(fv_times[0] - t0), 32'd15);
    chk("s4_addr", 32'(bus.addr_out), 32'h3);
    chk("s4_data", 32'(bus.data_out), 32'hC);

    // Back-to-back frames
    clear_mon();
    send_frame(FRAME_A5);
    send_frame(FRAME_3C);
    idle(2);
    chk("s3_fv_count", 32'(fv_times.size()), 32'h2);
    chk("s3_spacing", 32'(fv_times[1] - fv_times[0]), 32'd13);
    chk("s3_addr", 32'(bus.addr_out), 32'h3);
    chk("s3_data", 32'(bus.data_out), 32'hC);

    // Reset after 5 payload bits, then a full frame
    clear_mon();
    for (int i = 12; i >= 4; i--) send(FRAME_3C[i]);
    bus.ena = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("s5_rst_addr", 32'(bus.addr_out), 32'h0);
    chk("s5_rst_data", 32'(bus.data_out), 32'h0);
    chk("s5_rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("s5_rst_pe", 32'(bus.par_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(FRAME_3C);
    idle(2);
    chk("s5_fv_count", 32'(fv_times.size()), 32'h1);
    chk("s5_pe_count", 32'(pe_n), 32'h0);
    chk("s5_addr", 32'(bus.addr_out), 32'h3);
    chk("s5_data", 32'(bus.data_out), 32'hC);

    // Divider from reset with ena held high
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.ena      = 1'b1;
    bus.data_enc = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("div_k%0d", k), 32'(bus.clk_div), 32'((k / 4) % 2));
    end
    bus.ena = 1'b0;

    chk("never_both", 32'(both_n), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_frame_decrypt.md
# serial_frame_decrypt

Receives a framed serial bitstream, hunts for a plaintext sync word, and decrypts the payload with an internal LFSR keystream that restarts at every frame. It then deserialises the result into address and data words and checks even parity. Validated words are presented with a one-cycle strobe. The block sits where the fixed-key 4-bit receive/decrypt path sat. It generalises that path in word widths, key length and divider ratio, and adds framing, a self-generated keystream and error reporting.

## Interface
- ADDR_W, 4, address field width (≥1)
- DATA_W, 4, data field width (≥1)
- SYNC_W, 4, sync word length (≥2)
- SYNC_WORD, 4'b1011, sync pattern, MSB received first
- KEY_W, 8, LFSR length (≥3)
- KEY_SEED, 8'hA5, LFSR load value at frame start; must be nonzero (elaboration error otherwise)
- KEY_TAPS, 8'hB8, feedback tap mask
- DIV_HALF, 4, clk_div half-period in enabled cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  bit-enable; one serial bit is sampled per clk with ena=1
- data_enc  in  1  serial input (sync plaintext, payload encrypted)
- clk_div  out  1  divided clock, 50% duty
- addr_out  out  ADDR_W  last valid address
- data_out  out  DATA_W  last valid data
- frame_valid  out  1  one-cycle pulse when a frame passes parity
- par_err  out  1  one-cycle pulse when a frame fails parity

## Operation
- Reset values: all outputs 0, FSM HUNT, sync shift register 0, LFSR = KEY_SEED, bit counter 0, divider counter 0.
- ena=0 freezes the FSM, shift registers, LFSR, counter and divider. Pending pulses still fall after one clk.
- HUNT: shift data_enc into sync_sr on each enabled cycle. If {sync_sr[SYNC_W-2:0], data_enc} == SYNC_WORD:
  - go to RECV
  - load LFSR = KEY_SEED
  - clear the counter
- RECV: on each enabled cycle, plain = data_enc ^ lfsr[0].
  - Shift plain into the payload register; LFSR steps to {^(lfsr & KEY_TAPS), lfsr[KEY_W-1:1]}; counter increments.
  - Frame order: ADDR_W address bits (MSB first), then DATA_W data bits (MSB first), then 1 parity bit. Frame length is N = ADDR_W+DATA_W+1.
- Last payload bit (counter = N-1): XOR all N decrypted bits.
  - Result 0: register addr_out/data_out and pulse frame_valid.
  - Result 1: pulse par_err; addr_out/data_out are held.
  - Either way: return to HUNT with sync_sr cleared.
- Sync bits are never decrypted and never advance the LFSR. Sync detection is inactive during RECV.
- clk_div toggles every DIV_HALF enabled cycles, independent of the FSM.

## Timing
- Latency: frame_valid/par_err and the new addr_out/data_out appear on the clk edge that samples the last payload bit. They are visible in the following cycle.
- Back-to-back frames: the next sync bit may arrive on the enabled cycle right after the parity bit. There are no dead cycles.
- The sync match edge and the first payload bit are separate enabled cycles.
- Reset asserted mid-frame: immediate return to reset values. Any partial frame is discarded and no pulse is produced.
- frame_valid and par_err are never high together.

## Structure
- Shared package holds:
  - FSM state encoding (HUNT, RECV)
  - LFSR next-state function
  - default SYNC_WORD / KEY_SEED / KEY_TAPS constants
  - frame length function ADDR_W+DATA_W+1
- One sub-module, lfsr_keystream. Inputs: clk, rst_n, load, step. Output: ks_bit = lfsr[0]. It is also reusable by the future transmit/encrypt block.
- Divider stays inline; it is a counter plus a toggle flop.

## Test plan
- Defaults, ena=1: send 1011 then 100110010. Keystream is 101001010 and plaintext is addr 3, data C, parity 0. Expect addr_out=4'h3, data_out=4'hC, and frame_valid high for exactly 1 cycle.
- Same frame with the last bit inverted (100110011): expect par_err for 1 cycle, addr_out/data_out unchanged, frame_valid stays 0.
- Two valid frames sent back-to-back, the second being 1011 + 100110010 again: expect two frame_valid pulses 13 enabled cycles apart. This confirms the LFSR reload at each frame.
- First frame sent with ena deasserted for 3 random cycles between bits: expect the same result as scenario 1, with the pulse delayed by exactly the gap length.
- rst_n pulsed low after 5 payload bits, then a complete valid frame sent: expect no pulse from the aborted frame, then a correct frame_valid. Outputs read 0 during reset.
- ena=1 held for 32 cycles after reset: expect clk_div to toggle at cycles 4, 8, 12, and so on, giving a period of 8.
